channelizer_fifo_n: RTL and testbench

- Parametrised, clocked successor to the 4-way channel demultiplexer.
- Takes one channel-tagged Avalon-ST-style stream (data + 2-bit error + channel index) and steers each accepted beat into one of NCH per-channel FIFOs.
- Each FIFO presents an independent valid/ready output stream.
- Sits between the DDC decimation chain output (interleaved I/Q or RX1/RX2 beats) and the per-channel consumers (audio/IQ packers), replacing valid-edge-clocked latching with proper buffering, backpressure and stream-integrity flags.

---
 rtl/channelizer_fifo_n.sv | 138 +++++++++++++
 tb/tb_channelizer_fifo_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/channelizer_fifo_n.sv
// Channel-tagged stream demultiplexer feeding NCH independent first-word-fall-through FIFOs,
// with per-channel backpressure, bad-channel/sequence pulses and sticky overflow flags.
module channelizer_fifo_n #(
   parameter int WIDTH     = 32,
   parameter int NCH       = 4,
   parameter int CHW       = 2,
   parameter int DEPTH     = 8,
   parameter int SEQ_CHECK = 1
) (
   input  logic                                clk_in,
   input  logic                                reset_n,
   input  logic [WIDTH-1:0]                    in_data,
   input  logic [1:0]                          in_error,
   input  logic [CHW-1:0]                      in_channel,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [NCH*WIDTH-1:0]                out_data,
   output logic [NCH*2-1:0]                    out_error,
   output logic [NCH-1:0]                      out_valid,
   input  logic [NCH-1:0]                      out_ready,
   output logic [NCH*($clog2(DEPTH)+1)-1:0]    fill_level,
   output logic                                bad_channel,
   output logic                                seq_error,
   output logic [NCH-1:0]                      overflow_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 2;

   logic [NCH-1:0] ch_hit;
   logic [NCH-1:0] full;
   logic [NCH-1:0] wr_en;
   logic [NCH-1:0] rd_en;
   logic           ch_in_range;
   logic           accept;

   logic [CHW-1:0] expected_q, expected_d;
   logic [CHW-1:0] next_ch;
   logic           seq_error_q, seq_error_d;
   logic           bad_channel_q, bad_channel_d;

   // Decode the destination; out-of-range channels match nothing and are always sunk.
   always_comb begin
      ch_hit   = '0;
      in_ready = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if (in_channel == CHW'(k)) begin
            ch_hit[k] = 1'b1;
            in_ready  = ~full[k];
         end
      end
   end

   assign ch_in_range = |ch_hit;
   assign accept      = in_valid & in_ready;
   assign wr_en       = {NCH{accept}} & ch_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [EW-1:0] mem [DEPTH];
         logic [AW-1:0] wr_ptr_q, rd_ptr_q;
         logic [CW-1:0] count_q, count_d;
         logic          overflow_q;
         logic [EW-1:0] head;

         assign full[gi]      = (count_q == CW'(DEPTH));
         assign out_valid[gi] = (count_q != '0);
         assign rd_en[gi]     = out_valid[gi] & out_ready[gi];

         always_ff @(posedge clk_in) begin
            if (wr_en[gi]) begin
               mem[wr_ptr_q] <= {in_error, in_data};
            end
         end

         always_comb begin
            count_d = count_q;
            case ({wr_en[gi], rd_en[gi]})
               2'b10:   count_d = count_q + CW'(1);
               2'b01:   count_d = count_q - CW'(1);
               default: count_d = count_q;
            endcase
         end

         always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
               wr_ptr_q   <= '0;
               rd_ptr_q   <= '0;
               count_q    <= '0;
               overflow_q <= 1'b0;
            end else begin
               if (wr_en[gi]) wr_ptr_q <= wr_ptr_q + AW'(1);
               if (rd_en[gi]) rd_ptr_q <= rd_ptr_q + AW'(1);
               count_q <= count_d;
               if (in_valid && ch_hit[gi] && full[gi]) overflow_q <= 1'b1;
            end
         end

         // Empty FIFOs present zero so stale RAM contents never leak out after reset.
         assign head = mem[rd_ptr_q];
         assign out_data[gi*WIDTH +: WIDTH] = out_valid[gi] ? head[WIDTH-1:0] : '0;
         assign out_error[gi*2 +: 2]        = out_valid[gi] ? head[EW-1:WIDTH] : 2'b00;
         assign fill_level[gi*CW +: CW]     = count_q;
         assign overflow_seen[gi]           = overflow_q;
      end
   endgenerate

   assign next_ch = (in_channel == CHW'(NCH - 1)) ? '0 : in_channel + CHW'(1);

   // Match or mismatch, the next expected channel always follows the accepted one.
   always_comb begin
      expected_d    = expected_q;
      seq_error_d   = 1'b0;
      bad_channel_d = in_valid & ~ch_in_range;
      if ((SEQ_CHECK != 0) && accept && ch_in_range) begin
         seq_error_d = (in_channel != expected_q);
         expected_d  = next_ch;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         expected_q    <= '0;
         seq_error_q   <= 1'b0;
         bad_channel_q <= 1'b0;
      end else begin
         expected_q    <= expected_d;
         seq_error_q   <= seq_error_d;
         bad_channel_q <= bad_channel_d;
      end
   end

   assign seq_error   = seq_error_q;
   assign bad_channel = bad_channel_q;

endmodule

// File: tb/tb_channelizer_fifo_n.sv
// Directed bench for channelizer_fifo_n: a 4-channel instance for the main plan and
// a 3-channel instance for the out-of-range channel case.
module tb_channelizer_fifo_n;

   logic clk_in = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: NCH=4, DEPTH=8, SEQ_CHECK=1
   logic [31:0]  a_in_data;
   logic [1:0]   a_in_error;
   logic [1:0]   a_in_channel;
   logic         a_in_valid;
   logic         a_in_ready;
   logic [127:0] a_out_data;
   logic [7:0]   a_out_error;
   logic [3:0]   a_out_valid;
   logic [3:0]   a_out_ready;
   logic [15:0]  a_fill;
   logic         a_bad;
   logic         a_seq;
   logic [3:0]   a_ovf;

   // Instance B: NCH=3, CHW=2, DEPTH=8, SEQ_CHECK=1
   logic [31:0]  b_in_data;
   logic [1:0]   b_in_error;
   logic [1:0]   b_in_channel;
   logic         b_in_valid;
   logic         b_in_ready;
   logic [95:0]  b_out_data;
   logic [5:0]   b_out_error;
   logic [2:0]   b_out_valid;
   logic [2:0]   b_out_ready;
   logic [11:0]  b_fill;
   logic         b_bad;
   logic         b_seq;
   logic [2:0]   b_ovf;

   channelizer_fifo_n #(.WIDTH(32), .NCH(4), .CHW(2), .DEPTH(8), .SEQ_CHECK(1)) u_dut_a (
      .clk_in(clk_in), .reset_n(reset_n),
      .in_data(a_in_data), .in_error(a_in_error), .in_channel(a_in_channel),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_error(a_out_error), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .fill_level(a_fill),
      .bad_channel(a_bad), .seq_error(a_seq), .overflow_seen(a_ovf)
   );

   channelizer_fifo_n #(.WIDTH(32), .NCH(3), .CHW(2), .DEPTH(8), .SEQ_CHECK(1)) u_dut_b (
      .clk_in(clk_in), .reset_n(reset_n),
      .in_data(b_in_data), .in_error(b_in_error), .in_channel(b_in_channel),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_error(b_out_error), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .fill_level(b_fill),
      .bad_channel(b_bad), .seq_error(b_seq), .overflow_seen(b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      a_in_valid = 1'b0; a_in_data = '0; a_in_error = '0; a_in_channel = '0; a_out_ready = '0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_error = '0; b_in_channel = '0; b_out_ready = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic beat_a(input logic [1:0] ch, input logic [31:0] d);
      a_in_channel = ch;
      a_in_data    = d;
      a_in_error   = d[1:0];
      a_in_valid   = 1'b1;
   endtask

   logic acc;
   int   n_acc;
   logic [1:0] ord [5];

   initial begin
      do_reset();

      // Reset state
      check("rst out_valid", 32'(a_out_valid), 32'h0);
      check("rst fill", 32'(a_fill), 32'h0);
      check("rst out_data lo", a_out_data[31:0], 32'h0);
      check("rst flags", {28'h0, a_bad, a_seq, a_ovf[1:0]}, 32'h0);
      check("rst in_ready", 32'(a_in_ready), 32'h1);

      // Test 1: one beat per channel, consumers always ready
      a_out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         beat_a(2'(i), 32'h11 * (i + 1));
         tick();
         check($sformatf("t1 out_valid ch%0d", i), 32'(a_out_valid), 32'(1 << i));
         check($sformatf("t1 out_data ch%0d", i), a_out_data[i*32 +: 32], 32'h11 * (i + 1));
         check($sformatf("t1 out_error ch%0d", i), 32'(a_out_error[i*2 +: 2]), 32'(i + 1) & 32'h3);
         check($sformatf("t1 seq_error %0d", i), 32'(a_seq), 32'h0);
      end
      a_in_valid = 1'b0;
      tick();
      check("t1 drained", 32'(a_out_valid), 32'h0);

      // Test 2: fill ch2 while its consumer stalls, then overflow and drain
      do_reset();
      a_out_ready = 4'b1011;
      for (int i = 0; i < 8; i++) begin
         beat_a(2'd2, 32'h200 + 32'(i));
         tick();
         if (i == 3) begin
            beat_a(2'd0, 32'h77);
            tick();
         end
      end
      check("t2 fill ch2 full", 32'(a_fill[8 +: 4]), 32'd8);
      beat_a(2'd2, 32'h208);
      #1;
      check("t2 in_ready full", 32'(a_in_ready), 32'h0);
      tick();
      check("t2 overflow_seen", 32'(a_ovf), 32'h4);
      check("t2 fill still 8", 32'(a_fill[8 +: 4]), 32'd8);
      a_out_ready = 4'b1111;
      n_acc = 0;
      for (int j = 0; j < 9; j++) begin
         check($sformatf("t2 drain valid %0d", j), 32'(a_out_valid[2]), 32'h1);
         check($sformatf("t2 drain data %0d", j), a_out_data[64 +: 32], 32'h200 + 32'(j));
         acc = a_in_valid & a_in_ready;
         tick();
         if (acc) begin
            a_in_valid = 1'b0;
            n_acc++;
         end
      end
      check("t2 held beat accepted once", 32'(n_acc), 32'd1);
      check("t2 ch2 empty", 32'(a_out_valid[2]), 32'h0);
      check("t2 fill 0", 32'(a_fill[8 +: 4]), 32'd0);
      check("t2 overflow sticky", 32'(a_ovf), 32'h4);

      // Test 6: asynchronous reset with 5 entries queued on ch0
      do_reset();
      a_out_ready = 4'b1110;
      for (int i = 0; i < 5; i++) begin
         beat_a(2'd0, 32'h600 + 32'(i));
         tick();
      end
      a_in_valid = 1'b0;
      check("t6 fill 5", 32'(a_fill[0 +: 4]), 32'd5);
      #3;
      reset_n = 1'b0;
      #1;
      check("t6 async out_valid", 32'(a_out_valid), 32'h0);
      check("t6 async fill", 32'(a_fill), 32'h0);
      check("t6 async out_data", a_out_data[31:0], 32'h0);
      @(posedge clk_in);
      #1;
      reset_n = 1'b1;
      beat_a(2'd0, 32'h55);
      #1;
      check("t6 not visible at T", 32'(a_out_valid), 32'h0);
      tick();
      a_in_valid = 1'b0;
      check("t6 visible at T+1", 32'(a_out_valid), 32'h1);
      check("t6 data", a_out_data[31:0], 32'h55);
      check("t6 fill 1", 32'(a_fill[0 +: 4]), 32'd1);

      // Test 3: ch1 held at one entry with a write and read every cycle
      do_reset();
      beat_a(2'd1, 32'h100);
      tick();
      a_out_ready = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         check($sformatf("t3 valid %0d", i), 32'(a_out_valid[1]), 32'h1);
         check($sformatf("t3 fill %0d", i), 32'(a_fill[4 +: 4]), 32'd1);
         check($sformatf("t3 data %0d", i), a_out_data[32 +: 32], 32'h100 + 32'(i));
         beat_a(2'd1, 32'h101 + 32'(i));
         tick();
      end
      a_in_valid = 1'b0;

      // Test 4: channel order 0,1,3,0,1 -> single sequence error after the ch3 beat
      do_reset();
      a_out_ready = 4'b1111;
      ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd3; ord[3] = 2'd0; ord[4] = 2'd1;
      for (int i = 0; i < 5; i++) begin
         beat_a(ord[i], 32'h40 + 32'(i));
         tick();
         check($sformatf("t4 seq_error %0d", i), 32'(a_seq), (i == 2) ? 32'h1 : 32'h0);
         check($sformatf("t4 valid %0d", i), 32'(a_out_valid), 32'(1 << ord[i]));
         check($sformatf("t4 data %0d", i), a_out_data[ord[i]*32 +: 32], 32'h40 + 32'(i));
      end
      a_in_valid = 1'b0;
      tick();
      check("t4 seq quiet", 32'(a_seq), 32'h0);

      // Test 5: out-of-range channel on the 3-channel instance
      do_reset();
      b_out_ready = 3'b111;
      b_in_channel = 2'd0; b_in_data = 32'hB0; b_in_valid = 1'b1;
      tick();
      b_in_channel = 2'd3; b_in_data = 32'hDEAD;
      #1;
      check("t5 in_ready ch3", 32'(b_in_ready), 32'h1);
      tick();
      check("t5 bad_channel pulse", 32'(b_bad), 32'h1);
      check("t5 no fifo change", 32'(b_out_valid), 32'h0);
      check("t5 fill 0", 32'(b_fill), 32'h0);
      b_in_channel = 2'd1; b_in_data = 32'hB1;
      tick();
      b_in_valid = 1'b0;
      check("t5 bad_channel done", 32'(b_bad), 32'h0);
      check("t5 expected unchanged", 32'(b_seq), 32'h0);
      check("t5 ch1 delivered", b_out_data[32 +: 32], 32'hB1);
      check("t5 ch1 valid", 32'(b_out_valid), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
